// File: rtl/wm8978_pkg.sv
// rtl/wm8978_pkg.sv - shared constants, register addresses and FSM states for the WM8978 boot sequencer
package wm8978_pkg;

    localparam logic [23:0] PWRUP_CYC_DEF = 24'd5_000_000;
    localparam logic [4:0]  REG_NUM       = 5'd19;
    localparam logic [1:0]  MAX_RETRY_DEF = 2'd2;
    localparam logic [5:0]  VOL_DEF       = 6'd40;

    localparam logic [6:0] R0_RESET    = 7'd0;
    localparam logic [6:0] R1_PWR1     = 7'd1;
    localparam logic [6:0] R2_PWR2     = 7'd2;
    localparam logic [6:0] R3_PWR3     = 7'd3;
    localparam logic [6:0] R4_AIF      = 7'd4;
    localparam logic [6:0] R6_CLKGEN   = 7'd6;
    localparam logic [6:0] R7_ADDCTL   = 7'd7;
    localparam logic [6:0] R10_DACCTL  = 7'd10;
    localparam logic [6:0] R14_ADCCTL  = 7'd14;
    localparam logic [6:0] R15_LADCVOL = 7'd15;
    localparam logic [6:0] R16_RADCVOL = 7'd16;
    localparam logic [6:0] R43_BEEP    = 7'd43;
    localparam logic [6:0] R44_INPPGA  = 7'd44;
    localparam logic [6:0] R45_LPGAVOL = 7'd45;
    localparam logic [6:0] R46_RPGAVOL = 7'd46;
    localparam logic [6:0] R47_LBOOST  = 7'd47;
    localparam logic [6:0] R48_RBOOST  = 7'd48;
    localparam logic [6:0] R52_LOUT1   = 7'd52;
    localparam logic [6:0] R53_ROUT1   = 7'd53;

    localparam int         HPVU_BIT = 8;
    localparam logic [8:0] HPVU_SET = 9'(1 << HPVU_BIT);

    typedef enum logic [2:0] {
        ST_PWRUP, ST_LOAD, ST_EXEC, ST_WAIT, ST_NEXT, ST_READY, ST_VOL_L, ST_VOL_R
    } cfg_state_t;

    function automatic logic [15:0] i2c_word(input logic [6:0] addr, input logic [8:0] val);
        return {addr, val};
    endfunction

endpackage

// File: rtl/wm8978_cfg_seq_if.sv
// rtl/wm8978_cfg_seq_if.sv - write-only command/response port to the shared I2C driver
interface wm8978_cfg_seq_if;
    logic        exec;
    logic [15:0] data;
    logic        done;
    logic        ack;

    modport master (output exec, output data, input done, input ack);
    modport slave  (input exec, input data, output done, output ack);
endinterface

// File: rtl/wm8978_cfg_rom.sv
// rtl/wm8978_cfg_rom.sv - boot register table: I2S 32-bit slave, mic/ADC path on, headphone volume preset
module wm8978_cfg_rom
    import wm8978_pkg::*;
#(
    parameter logic [5:0] VOL = VOL_DEF
) (
    input  logic [4:0]  idx,
    output logic [15:0] word
);

    always_comb begin
        word = '0;
        case (idx)
            5'd0:  word = i2c_word(R0_RESET,    9'h000);
            5'd1:  word = i2c_word(R1_PWR1,     9'h01B);
            5'd2:  word = i2c_word(R2_PWR2,     9'h1B3);
            5'd3:  word = i2c_word(R3_PWR3,     9'h06F);
            5'd4:  word = i2c_word(R4_AIF,      9'h070);
            5'd5:  word = i2c_word(R6_CLKGEN,   9'h000);
            5'd6:  word = i2c_word(R7_ADDCTL,   9'h000);
            5'd7:  word = i2c_word(R10_DACCTL,  9'h008);
            5'd8:  word = i2c_word(R14_ADCCTL,  9'h108);
            5'd9:  word = i2c_word(R15_LADCVOL, 9'h1FF);
            5'd10: word = i2c_word(R16_RADCVOL, 9'h1FF);
            5'd11: word = i2c_word(R43_BEEP,    9'h010);
            5'd12: word = i2c_word(R44_INPPGA,  9'h033);
            5'd13: word = i2c_word(R45_LPGAVOL, 9'h13F);
            5'd14: word = i2c_word(R46_RPGAVOL, 9'h13F);
            5'd15: word = i2c_word(R47_LBOOST,  9'h100);
            5'd16: word = i2c_word(R48_RBOOST,  9'h100);
            // Left is staged without HPVU; the right write latches both channels together.
            5'd17: word = i2c_word(R52_LOUT1,   {3'b000, VOL});
            5'd18: word = i2c_word(R53_ROUT1,   HPVU_SET | {3'b000, VOL});
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/wm8978_cfg_seq.sv
// rtl/wm8978_cfg_seq.sv - WM8978 boot sequencer with NACK retry and runtime headphone volume writes
module wm8978_cfg_seq
    import wm8978_pkg::*;
#(
    parameter logic [23:0] PWRUP_CYC = PWRUP_CYC_DEF,
    parameter logic [1:0]  MAX_RETRY = MAX_RETRY_DEF,
    parameter logic [5:0]  VOL_INIT  = VOL_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    wm8978_cfg_seq_if.master         i2c,
    input  logic                     vol_req,
    input  logic [5:0]               vol_val,
    output logic                     vol_busy,
    output logic                     cfg_done,
    output logic                     cfg_err
);

    cfg_state_t  state;
    cfg_state_t  ret_st;
    logic [23:0] dly_cnt;
    logic [4:0]  idx;
    logic [1:0]  retry;
    logic        pending;
    logic [5:0]  vol_lat;
    logic [5:0]  vol_cur;
    logic [15:0] rom_word;

    wm8978_cfg_rom #(.VOL(VOL_INIT)) u_rom (
        .idx  (idx),
        .word (rom_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_PWRUP;
            ret_st   <= ST_NEXT;
            dly_cnt  <= '0;
            idx      <= '0;
            retry    <= '0;
            pending  <= 1'b0;
            vol_lat  <= '0;
            vol_cur  <= '0;
            i2c.exec <= 1'b0;
            i2c.data <= '0;
            vol_busy <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            i2c.exec <= 1'b0;
            case (state)
                ST_PWRUP: begin
                    if (dly_cnt == PWRUP_CYC - 24'd1) state <= ST_LOAD;
                    else dly_cnt <= dly_cnt + 24'd1;
                end
                ST_LOAD: begin
                    i2c.data <= rom_word;
                    ret_st   <= ST_NEXT;
                    i2c.exec <= 1'b1;
                    state    <= ST_EXEC;
                end
                ST_EXEC: state <= ST_WAIT;
                ST_WAIT: begin
                    if (i2c.done) begin
                        if (i2c.ack && retry != MAX_RETRY) begin
                            retry    <= retry + 2'd1;
                            i2c.exec <= 1'b1;
                            state    <= ST_EXEC;
                        end else begin
                            if (i2c.ack) cfg_err <= 1'b1;
                            retry <= '0;
                            state <= ret_st;
                        end
                    end
                end
                ST_NEXT: begin
                    if (idx == REG_NUM - 5'd1) begin
                        state    <= ST_READY;
                        cfg_done <= 1'b1;
                    end else begin
                        idx   <= idx + 5'd1;
                        state <= ST_LOAD;
                    end
                end
                ST_READY: begin
                    // Snapshot so both halves of a pair carry the same volume.
                    if (pending) begin
                        vol_cur <= vol_lat;
                        state   <= ST_VOL_L;
                    end
                end
                ST_VOL_L: begin
                    i2c.data <= i2c_word(R52_LOUT1, {3'b000, vol_cur});
                    ret_st   <= ST_VOL_R;
                    i2c.exec <= 1'b1;
                    state    <= ST_EXEC;
                end
                ST_VOL_R: begin
                    i2c.data <= i2c_word(R53_ROUT1, HPVU_SET | {3'b000, vol_cur});
                    ret_st   <= ST_READY;
                    i2c.exec <= 1'b1;
                    state    <= ST_EXEC;
                end
            endcase

            if (vol_req) begin
                vol_lat  <= vol_val;
                pending  <= 1'b1;
                vol_busy <= 1'b1;
            end else if (state == ST_READY) begin
                if (pending) pending  <= 1'b0;
                else         vol_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wm8978_cfg_seq.sv
// tb/tb_wm8978_cfg_seq.sv - scoreboard bench: boot, NACK retry/skip, volume writes, mid-boot reset
module tb_wm8978_cfg_seq;
    import wm8978_pkg::*;

    localparam int REGN = 19;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vol_req = 1'b0;
    logic [5:0] vol_val = '0;
    logic       vol_busy, cfg_done, cfg_err;

    always #5 clk = ~clk;

    wm8978_cfg_seq_if i2c ();

    wm8978_cfg_seq #(.PWRUP_CYC(24'd100)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i2c      (i2c),
        .vol_req  (vol_req),
        .vol_val  (vol_val),
        .vol_busy (vol_busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    logic [15:0] exp_rom [REGN] = '{
        16'h0000, 16'h021B, 16'h05B3, 16'h066F, 16'h0870, 16'h0C00, 16'h0E00,
        16'h1408, 16'h1D08, 16'h1FFF, 16'h21FF, 16'h5610, 16'h5833, 16'h5B3F,
        16'h5D3F, 16'h5F00, 16'h6100, 16'h6828, 16'h6B28
    };

    typedef struct {
        logic [15:0] data;
        logic        overlap;
    } obs_t;

    obs_t        obs_q[$];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    int          cyc = 0;
    int          rel_cyc = 0;
    int          exec_count;
    int          first_cyc;
    int          nack_seen;
    int          dcnt;
    bit          outstanding;
    bit          nack_this;
    logic [15:0] nack_data = 16'hFFFF;
    int          nack_limit = 0;

    always @(posedge clk) cyc++;

    // I2C driver model: done (with optional NACK) 20 cycles after each exec.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2c.done    = 1'b0;
            i2c.ack     = 1'b0;
            outstanding = 1'b0;
            exec_count  = 0;
            first_cyc   = -1;
            nack_seen   = 0;
            dcnt        = 0;
            obs_q.delete();
        end else begin
            i2c.done = 1'b0;
            i2c.ack  = 1'b0;
            if (outstanding) begin
                dcnt--;
                if (dcnt == 0) begin
                    i2c.done    = 1'b1;
                    i2c.ack     = nack_this;
                    outstanding = 1'b0;
                end
            end
            if (i2c.exec) begin
                obs_q.push_back('{data: i2c.data, overlap: outstanding});
                exec_count++;
                if (first_cyc < 0) first_cyc = cyc - rel_cyc;
                nack_this = (i2c.data == nack_data) && (nack_seen < nack_limit);
                if (nack_this) nack_seen++;
                outstanding = 1'b1;
                dcnt        = 20;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drain();
        obs_t o;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check_val("exec_overlap", 32'(o.overlap), 0);
            check_val("exec_expected_avail", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_val("exec_data", 32'(o.data), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_exec"}, 32'(i2c.exec), 0);
        check_val({tag, "_data"}, 32'(i2c.data), 0);
        check_val({tag, "_busy"}, 32'(vol_busy), 0);
        check_val({tag, "_done"}, 32'(cfg_done), 0);
        check_val({tag, "_err"},  32'(cfg_err),  0);
    endtask

    task automatic do_reset(input logic [15:0] nd, input int nl);
        rst_n = 1'b0;
        exp_q.delete();
        nack_data  = nd;
        nack_limit = nl;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        #2;
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic push_boot(input int dup_idx, input int dup_n);
        for (int i = 0; i < REGN; i++) begin
            exp_q.push_back(exp_rom[i]);
            if (i == dup_idx)
                for (int k = 0; k < dup_n; k++) exp_q.push_back(exp_rom[i]);
        end
    endtask

    task automatic wait_cfg_done(input int budget);
        int n = 0;
        while (!cfg_done && n < budget) begin
            step();
            n++;
        end
        check_val("cfg_done", 32'(cfg_done), 1);
        repeat (5) step();
    endtask

    task automatic pulse_vol(input logic [5:0] v);
        vol_val = v;
        vol_req = 1'b1;
        step();
        vol_req = 1'b0;
    endtask

    task automatic wait_busy_low(input int budget);
        int n = 0;
        while (vol_busy && n < budget) begin
            step();
            n++;
        end
        check_val("vol_busy_fall", 32'(vol_busy), 0);
        repeat (3) step();
    endtask

    initial begin
        int n;
        int base;

        // 1: clean boot
        do_reset(16'hFFFF, 0);
        push_boot(-1, 0);
        wait_cfg_done(3000);
        check_val("t1_first_exec_cyc", first_cyc, 101);
        check_val("t1_exec_total", exec_count, REGN);
        check_val("t1_cfg_err", 32'(cfg_err), 0);
        check_val("t1_exp_left", exp_q.size(), 0);

        // 4: runtime volume update after boot
        base = exec_count;
        exp_q.push_back(16'h682A);
        exp_q.push_back(16'h6B2A);
        pulse_vol(6'h2A);
        check_val("t4_busy_after_req", 32'(vol_busy), 1);
        wait_busy_low(500);
        check_val("t4_exec_delta", exec_count - base, 2);
        check_val("t4_exp_left", exp_q.size(), 0);

        // 2: entry 3 NACKed twice then ACKed
        do_reset(exp_rom[3], 2);
        push_boot(3, 2);
        wait_cfg_done(3000);
        check_val("t2_exec_total", exec_count, REGN + 2);
        check_val("t2_cfg_err", 32'(cfg_err), 0);
        check_val("t2_exp_left", exp_q.size(), 0);

        // 3: entry 5 NACKed on every attempt, skipped
        do_reset(exp_rom[5], 3);
        push_boot(5, 2);
        wait_cfg_done(3000);
        check_val("t3_exec_total", exec_count, REGN + 2);
        check_val("t3_cfg_err", 32'(cfg_err), 1);
        check_val("t3_exp_left", exp_q.size(), 0);
        repeat (50) step();
        check_val("t3_cfg_err_sticky", 32'(cfg_err), 1);
        check_val("t3_cfg_done_held", 32'(cfg_done), 1);

        // 5: request during boot, second request during the first left write
        do_reset(16'hFFFF, 0);
        push_boot(-1, 0);
        exp_q.push_back(16'h6810);
        exp_q.push_back(16'h6B10);
        exp_q.push_back(16'h6820);
        exp_q.push_back(16'h6B20);
        repeat (50) step();
        pulse_vol(6'h10);
        check_val("t5_busy_boot", 32'(vol_busy), 1);
        n = 0;
        while (exec_count < REGN + 1 && n < 3000) begin
            step();
            n++;
        end
        check_val("t5_reach_vol_l", exec_count, REGN + 1);
        pulse_vol(6'h20);
        wait_busy_low(1000);
        check_val("t5_exec_total", exec_count, REGN + 4);
        check_val("t5_exp_left", exp_q.size(), 0);

        // 6: reset while waiting on entry 7
        do_reset(16'hFFFF, 0);
        push_boot(-1, 0);
        n = 0;
        while (exec_count < 8 && n < 3000) begin
            step();
            n++;
        end
        check_val("t6_reach_entry7", exec_count, 8);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n   = 1'b1;
        rel_cyc = cyc;
        push_boot(-1, 0);
        wait_cfg_done(3000);
        check_val("t6_first_exec_cyc", first_cyc, 101);
        check_val("t6_exec_total", exec_count, REGN);
        check_val("t6_exp_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
